// File: rtl/mem_load_unit_if.sv
// Data-memory read bus between mem_load_unit (master) and the data memory (slave).
// Single read transaction: req held until ack, rdata valid with ack.
interface mem_load_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mem_load_unit.sv
// Load-side data-memory access controller: one bus read per request, with timeout and byte/half/word lane extraction.
// Optional build macro LOAD_ALIGN_CHECK_EN rejects misaligned half/word loads without touching the bus.
module mem_load_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_size,
  output logic        ld_busy,
  output logic        ld_done,
  output logic        ld_err,
  output logic [7:0]  ld_byte,
  output logic [15:0] ld_half,
  output logic [31:0] ld_word,
  mem_load_unit_if.master mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Timer value seen on the TIMEOUT-th BUS edge without an ack.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [31:0] addr_q;
  logic [7:0]  timer;
  logic        err_q;

  logic        capture;
  logic        set_err;
  logic        load_data;
  logic        zero_data;
  logic        misaligned;

`ifdef LOAD_ALIGN_CHECK_EN
  assign misaligned = ((ld_size == 2'b01) && ld_addr[0]) ||
                      ((ld_size == 2'b10) && (ld_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n   = state;
    capture   = 1'b0;
    set_err   = 1'b0;
    load_data = 1'b0;
    zero_data = 1'b0;
    unique case (state)
      IDLE: begin
        if (ld_req) begin
          capture = 1'b1;
          if ((ld_size == 2'b11) || misaligned) begin
            set_err = 1'b1;
            state_n = DONE;
          end else begin
            state_n = BUS;
          end
        end
      end
      BUS: begin
        // An ack on the expiry edge still completes cleanly.
        if (mem.mem_ack) begin
          load_data = 1'b1;
          state_n   = DONE;
        end else if (timer == TMO_LAST) begin
          set_err   = 1'b1;
          zero_data = 1'b1;
          state_n   = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      timer   <= '0;
      err_q   <= 1'b0;
      ld_byte <= '0;
      ld_half <= '0;
      ld_word <= '0;
    end else begin
      if (capture) begin
        addr_q <= ld_addr;
        timer  <= '0;
        err_q  <= set_err;
      end else if (set_err) begin
        err_q  <= 1'b1;
      end

      if (state == BUS) timer <= timer + 8'd1;

      if (load_data) begin
        ld_byte <= mem.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half <= addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        ld_word <= mem.mem_rdata;
      end else if (zero_data) begin
        ld_byte <= '0;
        ld_half <= '0;
        ld_word <= '0;
      end
    end
  end

  // Decoded straight from the async-reset state register, so mem_req drops with rst_n.
  assign mem.mem_req  = (state == BUS);
  assign mem.mem_addr = {addr_q[31:2], 2'b00};
  assign ld_busy      = (state != IDLE);
  assign ld_done      = (state == DONE);
  assign ld_err       = (state == DONE) && err_q;

endmodule
